circuit_breaker_ctrl: RTL

//  Consumer end of the cb_load/cb_param breaker interface driven by the cascade detector (and any

---
 rtl/circuit_breaker_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/circuit_breaker_ctrl.sv
// -----------------------------------------------------------------------------
// circuit_breaker_ctrl
//
// Consumer end of the cb_load/cb_param breaker interface. Each 1-cycle load
// pulse becomes a timed market-protection state (NORMAL/THROTTLE/HALT/COOLDOWN),
// and the downstream order-valid stream is gated according to the current state.
//
// Ports
//   clk              clock
//   rst              synchronous active-high reset
//   cb_load          1-cycle load strobe
//   cb_param[7:0]    severity qualifying cb_load (0 = no-op)
//   op_clear         operator override, forces NORMAL (wins over cb_load)
//   order_valid_in   incoming order strobe
//   order_valid_out  registered gated order strobe (1 cycle latency)
//   cb_state[1:0]    0 NORMAL, 1 THROTTLE, 2 HALT, 3 COOLDOWN
//   halt_remaining   active timer (THROTTLE/HALT) or cooldown count; 0 in NORMAL
//   trip_pulse       1-cycle pulse on every entry into HALT
//   blocked_cnt      orders blocked since reset, saturating
// -----------------------------------------------------------------------------
module circuit_breaker_ctrl #(
  parameter int unsigned MIN_HALT     = 16,
  parameter int unsigned PARAM_SHIFT  = 2,
  parameter int unsigned HALT_THRESH  = 128,
  parameter int unsigned COOLDOWN_CYC = 32,
  parameter int unsigned THROTTLE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cb_load,
  input  logic [7:0]  cb_param,
  input  logic        op_clear,
  input  logic        order_valid_in,
  output logic        order_valid_out,
  output logic [1:0]  cb_state,
  output logic [11:0] halt_remaining,
  output logic        trip_pulse,
  output logic [15:0] blocked_cnt
);

  typedef enum logic [1:0] {
    StNormal   = 2'd0,
    StThrottle = 2'd1,
    StHalt     = 2'd2,
    StCooldown = 2'd3
  } state_e;

  localparam int unsigned PhW = (THROTTLE_DIV > 2) ? $clog2(THROTTLE_DIV) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(THROTTLE_DIV - 1);
  localparam logic [11:0] CoolLoad = (COOLDOWN_CYC > 4095) ? 12'hFFF : 12'(COOLDOWN_CYC);

  function automatic logic [11:0] sat12(input logic [31:0] v);
    return (v > 32'd4095) ? 12'hFFF : v[11:0];
  endfunction

  state_e         state_q, state_d;
  logic [11:0]    timer_q, timer_d;
  logic [PhW-1:0] phase_q, phase_d;
  logic           trip_q, trip_d;
  logic           ovo_q, ovo_d;
  logic [15:0]    blocked_q, blocked_d;

  // Load decode
  logic [31:0] p_ext, p_shift;
  logic        halt_lvl, thr_lvl;
  logic [11:0] th, th2, tt;

  always_comb begin
    p_ext    = {24'd0, cb_param};
    p_shift  = p_ext << PARAM_SHIFT;
    halt_lvl = cb_load && (cb_param != 8'd0) && (p_ext >= HALT_THRESH);
    thr_lvl  = cb_load && (cb_param != 8'd0) && (p_ext < HALT_THRESH);
    th       = sat12(p_shift + MIN_HALT);
    th2      = sat12({19'd0, th, 1'b0});  // escalation from COOLDOWN doubles the hold
    tt       = sat12(p_shift);
  end

  // Gate decision uses the registered state only
  logic pass;
  always_comb begin
    unique case (state_q)
      StNormal: pass = 1'b1;
      StHalt:   pass = 1'b0;
      default:  pass = (phase_q == '0);
    endcase
  end

  // Next-state / timer
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    trip_d  = 1'b0;

    // Natural countdown and exit on timer == 0
    unique case (state_q)
      StNormal: timer_d = 12'd0;
      StThrottle: begin
        if (timer_q == 12'd0) begin
          state_d = StNormal;
        end else begin
          timer_d = timer_q - 12'd1;
        end
      end
      StHalt: begin
        if (timer_q == 12'd0) begin
          state_d = StCooldown;
          timer_d = CoolLoad;
        end else begin
          timer_d = timer_q - 12'd1;
        end
      end
      StCooldown: begin
        if (timer_q == 12'd0) begin
          state_d = StNormal;
        end else begin
          timer_d = timer_q - 12'd1;
        end
      end
      default: state_d = StNormal;
    endcase

    // Accepted loads override the countdown, including on the exit cycle.
    // A load that would not raise the running timer is not accepted.
    if (halt_lvl) begin
      unique case (state_q)
        StNormal, StThrottle: begin
          state_d = StHalt;
          timer_d = th;
          trip_d  = 1'b1;
        end
        StHalt: begin
          if (th > timer_q) begin
            state_d = StHalt;
            timer_d = th;
          end
        end
        StCooldown: begin
          state_d = StHalt;
          timer_d = th2;
          trip_d  = 1'b1;
        end
        default: ;
      endcase
    end else if (thr_lvl) begin
      unique case (state_q)
        StNormal, StCooldown: begin
          state_d = StThrottle;
          timer_d = tt;
        end
        StThrottle: begin
          if (tt > timer_q) begin
            state_d = StThrottle;
            timer_d = tt;
          end
        end
        default: ;  // throttle-level ignored in HALT
      endcase
    end

    if (state_d == StNormal) begin
      timer_d = 12'd0;
    end

    if (op_clear) begin
      state_d = StNormal;
      timer_d = 12'd0;
      trip_d  = 1'b0;
    end
  end

  // Throttle phase, gated output, blocked counter
  always_comb begin
    phase_d   = phase_q;
    ovo_d     = order_valid_in && pass;
    blocked_d = blocked_q;

    if (order_valid_in && ((state_q == StThrottle) || (state_q == StCooldown))) begin
      phase_d = (phase_q == PhLast) ? '0 : phase_q + 1'b1;
    end
    // Any state change restarts the 1-in-N pattern; NORMAL/HALT hold it at 0
    if ((state_d != state_q) || (state_d == StNormal) || (state_d == StHalt)) begin
      phase_d = '0;
    end

    if (order_valid_in && !pass && (blocked_q != 16'hFFFF)) begin
      blocked_d = blocked_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StNormal;
      timer_q   <= 12'd0;
      phase_q   <= '0;
      trip_q    <= 1'b0;
      ovo_q     <= 1'b0;
      blocked_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      phase_q   <= phase_d;
      trip_q    <= trip_d;
      ovo_q     <= ovo_d;
      blocked_q <= blocked_d;
    end
  end

  assign order_valid_out = ovo_q;
  assign cb_state        = state_q;
  assign halt_remaining  = timer_q;
  assign trip_pulse      = trip_q;
  assign blocked_cnt     = blocked_q;

endmodule
